// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I main controller: FETCH/DECODE/EXEC/MEM/WB sequencing with a
// registered control word, phase-local write pulses, retire counter, HALT and bus timeout.
module multicycle_controller #(
   parameter int OPCODE_W    = 7,
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] Opcode,
   input  logic                instr_ready,
   input  logic                mem_ready,
   output logic                instr_req,
   output logic                IRWrite,
   output logic                MemRead,
   output logic                MemWrite,
   output logic                ALUSrc,
   output logic                MemtoReg,
   output logic [1:0]          ALUOp,
   output logic                Branch,
   output logic                JalrSel,
   output logic [1:0]          RWSel,
   output logic                Jump,
   output logic                RegWrite,
   output logic                PCWrite,
   output logic                retire,
   output logic                illegal,
   output logic                Halt,
   output logic                bus_err,
   output logic [2:0]          state,
   output logic [CNT_W-1:0]    retire_count
);

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_HALTED = 3'd5
   } state_e;

   typedef enum logic [3:0] {
      CL_R    = 4'd0,
      CL_LW   = 4'd1,
      CL_SW   = 4'd2,
      CL_BR   = 4'd3,
      CL_IMM  = 4'd4,
      CL_JAL  = 4'd5,
      CL_JALR = 4'd6,
      CL_LUI  = 4'd7,
      CL_HALT = 4'd8,
      CL_ILL  = 4'd9
   } class_e;

   typedef struct packed {
      logic       alu_src;
      logic       mem_to_reg;
      logic [1:0] alu_op;
      logic       branch;
      logic       jalr_sel;
      logic [1:0] rw_sel;
      logic       jump;
   } ctrl_t;

   localparam bit TO_EN  = (MEM_TIMEOUT > 0);
   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   function automatic class_e classify(input logic [6:0] opc);
      class_e cl;
      case (opc)
         7'b0110011: cl = CL_R;
         7'b0000011: cl = CL_LW;
         7'b0100011: cl = CL_SW;
         7'b1100011: cl = CL_BR;
         7'b0010011: cl = CL_IMM;
         7'b1101111: cl = CL_JAL;
         7'b1100111: cl = CL_JALR;
         7'b0110111: cl = CL_LUI;
         7'b1111111: cl = CL_HALT;
         default:    cl = CL_ILL;
      endcase
      return cl;
   endfunction

   // Same truth table as the single-cycle decoder; HALT and unknown opcodes decode to all zeros.
   function automatic ctrl_t decode_ctrl(input class_e cl);
      ctrl_t c;
      c = '0;
      case (cl)
         CL_R:    c.alu_op = 2'b10;
         CL_LW:   begin c.alu_src = 1'b1; c.mem_to_reg = 1'b1; end
         CL_SW:   c.alu_src = 1'b1;
         CL_BR:   begin c.alu_op = 2'b01; c.branch = 1'b1; end
         CL_IMM:  begin c.alu_src = 1'b1; c.alu_op = 2'b10; end
         CL_JAL:  begin c.rw_sel = 2'b01; c.jump = 1'b1; end
         CL_JALR: begin c.alu_src = 1'b1; c.jalr_sel = 1'b1; c.rw_sel = 2'b01; c.jump = 1'b1; end
         CL_LUI:  c.alu_src = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

   state_e              state_q, state_d;
   class_e              class_q, class_d;
   ctrl_t               ctrl_q, ctrl_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                bus_err_q, bus_err_d;
   logic [CNT_W-1:0]    count_q, count_d;

   class_e dec_class_s;
   logic   timeout_s;
   logic   instr_req_s;
   logic   ir_write_s;
   logic   mem_read_s;
   logic   mem_write_s;
   logic   reg_write_s;
   logic   pc_write_s;
   logic   illegal_s;

   assign dec_class_s = classify(Opcode[6:0]);
   assign timeout_s   = TO_EN && (wait_q == WAIT_LAST);

   // Next-state, control-word capture and phase pulses.
   always_comb begin
      state_d     = state_q;
      class_d     = class_q;
      ctrl_d      = ctrl_q;
      bus_err_d   = bus_err_q;
      instr_req_s = 1'b0;
      ir_write_s  = 1'b0;
      mem_read_s  = 1'b0;
      mem_write_s = 1'b0;
      reg_write_s = 1'b0;
      pc_write_s  = 1'b0;
      illegal_s   = 1'b0;
      case (state_q)
         ST_FETCH: begin
            instr_req_s = 1'b1;
            // A ready in the timeout cycle still completes the fetch.
            if (instr_ready) begin
               ir_write_s = 1'b1;
               state_d    = ST_DECODE;
            end else if (timeout_s) begin
               bus_err_d = 1'b1;
               state_d   = ST_HALTED;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_DECODE: begin
            class_d = dec_class_s;
            ctrl_d  = decode_ctrl(dec_class_s);
            case (dec_class_s)
               CL_HALT: state_d = ST_HALTED;
               CL_ILL: begin
                  illegal_s  = 1'b1;
                  pc_write_s = 1'b1;
                  state_d    = ST_FETCH;
               end
               default: state_d = ST_EXEC;
            endcase
         end
         ST_EXEC: begin
            case (class_q)
               CL_LW, CL_SW: state_d = ST_MEM;
               CL_BR: begin
                  pc_write_s = 1'b1;
                  state_d    = ST_FETCH;
               end
               default: state_d = ST_WB;
            endcase
         end
         ST_MEM: begin
            mem_read_s  = (class_q == CL_LW);
            mem_write_s = (class_q == CL_SW);
            if (mem_ready) begin
               if (class_q == CL_LW) begin
                  state_d = ST_WB;
               end else begin
                  pc_write_s = 1'b1;
                  state_d    = ST_FETCH;
               end
            end else if (timeout_s) begin
               bus_err_d = 1'b1;
               state_d   = ST_HALTED;
            end else begin
               state_d = ST_MEM;
            end
         end
         ST_WB: begin
            reg_write_s = 1'b1;
            pc_write_s  = 1'b1;
            state_d     = ST_FETCH;
         end
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_FETCH;
      endcase
   end

   // Wait counter restarts on every state change, so it only accumulates while stalled in FETCH or MEM.
   always_comb begin
      if (state_d != state_q) begin
         wait_d = '0;
      end else if (TO_EN && ((state_q == ST_FETCH) || (state_q == ST_MEM))) begin
         wait_d = wait_q + WAIT_W'(1);
      end else begin
         wait_d = wait_q;
      end
   end

   // Retired-instruction counter, wrapping naturally at 2^CNT_W.
   always_comb begin
      if (pc_write_s) begin
         count_d = count_q + CNT_W'(1);
      end else begin
         count_d = count_q;
      end
   end

   // State and control registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_FETCH;
         class_q   <= CL_ILL;
         ctrl_q    <= '0;
         wait_q    <= '0;
         bus_err_q <= 1'b0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         class_q   <= class_d;
         ctrl_q    <= ctrl_d;
         wait_q    <= wait_d;
         bus_err_q <= bus_err_d;
         count_q   <= count_d;
      end
   end

   // Requests and pulses are forced low while reset is asserted.
   assign instr_req    = instr_req_s & rst_n;
   assign IRWrite      = ir_write_s & rst_n;
   assign MemRead      = mem_read_s & rst_n;
   assign MemWrite     = mem_write_s & rst_n;
   assign RegWrite     = reg_write_s & rst_n;
   assign PCWrite      = pc_write_s & rst_n;
   assign retire       = pc_write_s & rst_n;
   assign illegal      = illegal_s & rst_n;

   assign ALUSrc       = ctrl_q.alu_src;
   assign MemtoReg     = ctrl_q.mem_to_reg;
   assign ALUOp        = ctrl_q.alu_op;
   assign Branch       = ctrl_q.branch;
   assign JalrSel      = ctrl_q.jalr_sel;
   assign RWSel        = ctrl_q.rw_sel;
   assign Jump         = ctrl_q.jump;
   assign Halt         = (state_q == ST_HALTED);
   assign bus_err      = bus_err_q;
   assign state        = state_q;
   assign retire_count = count_q;

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle successor to the single-cycle main decoder of the RISC-V core.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states, with ready-handshaked instruction and data memory.
- Holds the decoded control word in a register for the whole instruction, pulses the write enables only in their own phase, and counts retired instructions.
- Provides a sticky HALT state and a configurable memory-timeout fault.

Parameters:
- OPCODE_W, 7, opcode field width. The opcode encodings are fixed RV32I values in the low 7 bits.
- MEM_TIMEOUT, 16, maximum wait cycles for mem_ready in any phase. 0 disables the timeout.
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- Opcode  in  OPCODE_W  opcode of the instruction register. Valid from DECODE onward.
- instr_ready  in  1  instruction memory data valid.
- mem_ready  in  1  data memory access complete.
- instr_req  out  1  instruction fetch request.
- IRWrite  out  1  latch the instruction register.
- MemRead  out  1  data read request (LW).
- MemWrite  out  1  data write request (SW).
- ALUSrc  out  1  registered control word field.
- MemtoReg  out  1  registered control word field.
- ALUOp  out  2  registered control word field.
- Branch  out  1  registered control word field.
- JalrSel  out  1  registered control word field.
- RWSel  out  2  registered control word field.
- Jump  out  1  registered control word field.
- RegWrite  out  1  register-file write pulse.
- PCWrite  out  1  PC update pulse, once per retired instruction.
- retire  out  1  instruction-complete pulse. Equal to PCWrite.
- illegal  out  1  one-cycle pulse on an unknown opcode.
- Halt  out  1  sticky halted flag.
- bus_err  out  1  sticky memory-timeout flag.
- state  out  3  current state, for debug.
- retire_count  out  CNT_W  retired-instruction count.

Behaviour:
- Supported opcodes:
  - R=0110011, LW=0000011, SW=0100011, BR=1100011, IMM=0010011.
  - JAL=1101111, JALR=1100111, LUI=0110111, HALT=1111111.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALTED=5.
- Reset (rst_n=0 at a clk edge):
  - Takes priority over everything, including mid-access and HALTED.
  - state=FETCH, all outputs 0, counters 0.
  - An outstanding ready arriving after reset is ignored.
- FETCH:
  - instr_req=1.
  - On instr_ready: IRWrite=1 for that cycle, go to DECODE.
- DECODE:
  - Register the control word from Opcode. Field values equal the single-cycle decoder truth table: ALUSrc, MemtoReg, ALUOp, Branch, JalrSel, RWSel (01 for JAL/JALR, else 00), Jump.
  - The word is held stable until the next DECODE.
  - Transitions:
    - HALT -> HALTED.
    - Unknown opcode -> illegal=1, PCWrite=1, retire=1, then FETCH. The PC advances and no register or memory write occurs.
    - Any other opcode -> EXEC.
- EXEC (1 cycle):
  - LW or SW -> MEM.
  - BR -> PCWrite=1 (datapath applies Branch condition), retire, FETCH.
  - R, IMM, LUI, JAL, JALR -> WB.
- MEM:
  - MemRead=1 (LW) or MemWrite=1 (SW), held until mem_ready.
  - On mem_ready: LW -> WB; SW -> PCWrite=1, retire, FETCH.
- WB (1 cycle):
  - RegWrite=1, PCWrite=1, retire=1, then FETCH.
- Cycle counts with zero-wait memory (ready in the first cycle of the request):
  - R/IMM/LUI/JAL/JALR: 4 cycles.
  - LW: 5 cycles.
  - SW: 4 cycles.
  - BR: 3 cycles.
  - Illegal: 2 cycles.
- Pulse rules:
  - RegWrite and PCWrite are never high outside the phases listed above.
  - RegWrite is never high for SW, BR, or illegal opcodes.
- Timeout:
  - A wait counter resets on entry to FETCH or MEM and increments each cycle without ready.
  - If MEM_TIMEOUT>0 and the counter reaches MEM_TIMEOUT: bus_err=1, go to HALTED.
  - A ready arriving in the same cycle as the timeout wins (the access completes).
- HALTED:
  - Halt=1. All requests and pulses are 0.
  - Leaves only via reset.
  - Opcode and ready inputs are ignored.
- retire_count increments on each retire pulse and wraps at 2^CNT_W to 0.

Test Plan:
- rst_n=0 for 2 cycles, then IMM (0010011) with zero-wait memory -> states 0,1,2,4,0. ALUSrc=1, ALUOp=10. RegWrite and PCWrite high only in the WB cycle. retire_count=1.
- LW with mem_ready delayed 3 cycles -> MemRead high for 4 cycles. Path MEM->WB. MemtoReg=1. RegWrite pulses once. Total 8 cycles.
- SW then BR back-to-back -> MemWrite high in MEM and RegWrite never high. BR retires in 3 cycles with Branch=1, ALUOp=01. retire_count=2.
- Opcode 0000000 -> illegal pulse in DECODE along with PCWrite. No RegWrite, MemRead, or MemWrite. Next cycle is FETCH.
- Opcode 1111111 -> HALTED, Halt=1. 10 further cycles with instr_ready=1 give instr_req=0. Then rst_n=0 -> FETCH, Halt=0.
- MEM_TIMEOUT=4, SW with mem_ready held 0 -> bus_err=1 and HALTED after 4 wait cycles. Repeat with mem_ready=1 on cycle 4 -> completes normally, bus_err=0.
